// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared widths and skid-buffer state encoding for the one-hot decoder
package decoder_pkg;

  localparam int IN_W_DEF = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  function automatic int out_width(input int in_w);
    return 1 << in_w;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational index-to-one-hot decode with enable gate
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  localparam int OUT_W = out_width(IN_W)
) (
  input  logic [IN_W-1:0]  idx,
  input  logic             en,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_onehot_pipe.sv
// rtl/decoder_onehot_pipe.sv - pipelined one-hot decoder with 2-entry skid buffer; DECODER_CNT_EN adds out_cnt
module decoder_onehot_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  localparam int OUT_W = out_width(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot
`ifdef DECODER_CNT_EN
  ,
  output logic [15:0]      out_cnt
`endif
);

  skid_state_t      state;
  skid_state_t      state_nxt;
  logic [OUT_W-1:0] dec_word;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] skid_q;
  logic             in_ready_q;
  logic             accept;
  logic             xfer;
  logic             load_out_dec;
  logic             load_out_skid;
  logic             load_skid;

  onehot_dec #(.IN_W(IN_W)) u_dec (
    .idx    (in_idx),
    .en     (en),
    .onehot (dec_word)
  );

  assign out_valid  = (state != EMPTY);
  assign out_onehot = out_q;
  assign in_ready   = in_ready_q;
  assign accept     = in_valid && in_ready_q;
  assign xfer       = out_valid && out_ready;

  always_comb begin
    state_nxt     = state;
    load_out_dec  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_out_dec = 1'b1;
        end
      end
      ONE: begin
        case ({accept, xfer})
          2'b10: begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: load_out_dec = 1'b1;
          default: state_nxt = ONE;
        endcase
      end
      TWO: begin
        // The older word sits in out_q; on its transfer the skid word moves up.
        if (xfer) begin
          state_nxt     = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state      <= state_nxt;
      // Registered so in_ready never sees out_ready combinationally.
      in_ready_q <= (state_nxt != TWO);
      if (load_out_dec) begin
        out_q <= dec_word;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec_word;
      end
    end
  end

`ifdef DECODER_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'h0000;
    end else if (xfer && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// tb/tb_decoder_onehot_pipe.sv - self-checking bench for decoder_onehot_pipe (DECODER_CNT_EN optional)
module tb_decoder_onehot_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_idx = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_onehot;
`ifdef DECODER_CNT_EN
  logic [15:0] out_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] cnt_m = 16'h0000;
  bit          rst_last = 1'b1;
  int          xfer_total = 0;

  decoder_onehot_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot)
`ifdef DECODER_CNT_EN
    ,
    .out_cnt    (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: a FIFO of at most two words; reset empties it and holds in_ready low for one edge.
  always @(negedge clk) begin
    bit          mv;
    bit          mr;
    logic [15:0] w;
    mv = (exp_q.size() != 0);
    mr = !rst_last && (exp_q.size() < 2);
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, mv});
    chk("model_in_ready", {31'd0, in_ready}, {31'd0, mr});
    if (mv) chk("model_out_onehot", {16'd0, out_onehot}, {16'd0, exp_q[0]});
`ifdef DECODER_CNT_EN
    chk("model_out_cnt", {16'd0, out_cnt}, {16'd0, cnt_m});
`endif
    if (rst) begin
      exp_q.delete();
      cnt_m = 16'h0000;
      rst_last = 1'b1;
    end else begin
      rst_last = 1'b0;
      if (mv && out_ready) begin
        void'(exp_q.pop_front());
        xfer_total++;
        if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      end
      if (in_valid && mr) begin
        w = en ? (16'h0001 << in_idx) : 16'h0000;
        exp_q.push_back(w);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit [15:0] rdy_pat;
  int        base;

  initial begin
    rdy_pat = 16'b1011_0011_1000_1101;

    // reset state
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_onehot", {16'd0, out_onehot}, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // basic decode, idx 3
    out_ready = 1'b1; en = 1'b1; in_valid = 1'b1; in_idx = 4'd3;
    step();
    in_valid = 1'b0;
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_word", {16'd0, out_onehot}, 32'h0008);

    // disabled path, idx 9
    step();
    in_valid = 1'b1; en = 1'b0; in_idx = 4'd9;
    step();
    in_valid = 1'b0; en = 1'b1;
    chk("dis_valid", {31'd0, out_valid}, 32'd1);
    chk("dis_word", {16'd0, out_onehot}, 32'h0000);
    step();
`ifdef DECODER_CNT_EN
    chk("dis_cnt", {16'd0, out_cnt}, 32'd2);
`endif

    // backpressure: 5 then 12
    out_ready = 1'b0;
    in_valid = 1'b1; in_idx = 4'd5;
    step();
    in_idx = 4'd12;
    step();
    in_valid = 1'b0;
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_first_word", {16'd0, out_onehot}, 32'h0020);
    step();
    chk("bp_hold_word", {16'd0, out_onehot}, 32'h0020);
    out_ready = 1'b1;
    step();
    chk("bp_second_word", {16'd0, out_onehot}, 32'h1000);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // streaming 0..15
    base = xfer_total;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_idx = i[3:0];
      step();
      chk("stream_word", {16'd0, out_onehot}, 32'h1 << i);
    end
    in_valid = 1'b0;
    step();
    chk("stream_xfers", xfer_total - base, 32'd16);

    // irregular out_ready pattern with continuous input
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_idx = 4'((i * 5) % 16);
      en = (i % 3) != 0;
      out_ready = rdy_pat[i];
      step();
    end
    in_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
    repeat (3) step();

    // reset while in TWO
    out_ready = 1'b0;
    in_valid = 1'b1; in_idx = 4'd7;
    step();
    in_idx = 4'd2;
    step();
    in_valid = 1'b0;
    chk("mid_full", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_word", {16'd0, out_onehot}, 32'h0);
`ifdef DECODER_CNT_EN
    chk("mid_rst_cnt", {16'd0, out_cnt}, 32'd0);
`endif
    rst = 1'b0;
    step();
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("mid_still_empty", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_idx = 4'd1;
    step();
    in_valid = 1'b0;
    chk("mid_fresh_word", {16'd0, out_onehot}, 32'h0002);
    step();

`ifdef DECODER_CNT_EN
    // saturation
    force dut.cnt_q = 16'hFFFE;
    cnt_m = 16'hFFFE;
    #1;
    release dut.cnt_q;
    in_valid = 1'b1; in_idx = 4'd4;
    repeat (3) step();
    in_valid = 1'b0;
    repeat (2) step();
    chk("sat_cnt", {16'd0, out_cnt}, 32'hFFFF);
    step();
    chk("sat_hold", {16'd0, out_cnt}, 32'hFFFF);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
